// File: rtl/rvm_lsu_if.sv
// rvm_lsu_if: core request/response and memory-bus signals of rvm_lsu; slave = LSU side, master = core/memory side
interface rvm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic [3:0]  mem_b_en;
  logic        mem_error;
  logic        mem_stall;
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_error, mem_stall,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_c_en, mem_b_en
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_error, mem_stall,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_c_en, mem_b_en
  );
endinterface

// File: rtl/rvm_lsu.sv
// rvm_lsu: byte/half/word load-store unit; ports clk, reset (sync active-high) and bus (rvm_lsu_if.slave: req/rsp handshake plus mem_* pins)
module rvm_lsu #(
  parameter int STALL_LIMIT = 255
) (
  input logic       clk,
  input logic       reset,
  rvm_lsu_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam int CW = STALL_LIMIT > 0 ? $clog2(STALL_LIMIT + 1) : 1;
  logic [1:0]    state_q, state_d, size_q, size_d, off_q, off_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, lane, ext;
  logic [3:0]    ben_q, ben_d;
  logic          cen_q, cen_d, err_q, err_d, sgn_q, sgn_d, wr_q, wr_d, misal, timeout;
  logic [CW-1:0] cnt_q, cnt_d;
  assign misal = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign timeout = STALL_LIMIT != 0 && cnt_q == CW'(STALL_LIMIT - 1);
  assign lane = bus.mem_rdata >> {off_q, 3'b000};
  assign ext = size_q == 2'd0 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
               size_q == 2'd1 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : lane;
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    cen_d   = cen_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && bus.req_valid) begin
      size_d = bus.req_size;
      off_d  = bus.req_addr[1:0];
      sgn_d  = bus.req_signed;
      wr_d   = bus.req_write;
      if (misal) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        state_d = ACCESS;
        cen_d   = 1'b1;
        cnt_d   = '0;
        addr_d  = {bus.req_addr[31:2], 2'b00};
        ben_d   = bus.req_size == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
                  bus.req_size == 2'd1 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
        wdata_d = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                  bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
      end
    end else if (state_q == ACCESS) begin
      if (!bus.mem_stall) begin
        state_d = RESP;
        cen_d   = 1'b0;
        ben_d   = '0;
        err_d   = bus.mem_error;
        rdata_d = (wr_q || bus.mem_error) ? '0 : ext;
      end else begin
        cnt_d = (STALL_LIMIT != 0 && cnt_q != CW'(STALL_LIMIT)) ? cnt_q + CW'(1) : cnt_q;
        if (timeout) begin
          state_d = RESP;
          cen_d   = 1'b0;
          ben_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      off_q   <= '0;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      cen_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      cen_q   <= cen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_c_en  = cen_q;
  assign bus.mem_b_en  = ben_q;
endmodule

// File: tb/tb_rvm_lsu.sv
// tb_rvm_lsu: randomized scoreboard bench for rvm_lsu with a behavioural load/store reference model
module tb_rvm_lsu;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  rvm_lsu_if bus();
  rvm_lsu #(.STALL_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic bad_req(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] s, input logic sg, input logic [1:0] off);
    int nb = nbytes(s);
    logic [63:0] v;
    v = ({32'b0, d} >> (8 * int'(off))) & ((64'd1 << (8 * nb)) - 64'd1);
    if (sg && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_error", {31'b0, bus.rsp_error}, {31'b0, mon_e.err});
        chk("rsp_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w == 20) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic access(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int nst, input logic [31:0] rd, input logic er);
    exp_t e;
    int nb = nbytes(sz);
    logic to = nst >= LIMIT;
    logic [31:0] ea = {a[31:2], 2'b00};
    logic [3:0] eb = 4'(((1 << nb) - 1) << a[1:0]);
    logic [31:0] ew = sz == 2'd0 ? {24'b0, wd[7:0]} * 32'h01010101 :
                      sz == 2'd1 ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (bad_req(sz, a)) begin
      e.rdata = '0;
      e.err   = 1'b1;
      e.at    = cyc;
      q.push_back(e);
      @(negedge clk);
      chk("no_mem_c_en", {31'b0, bus.mem_c_en}, 32'd0);
      return;
    end
    e.err   = to || er;
    e.rdata = (to || wr || er) ? 32'd0 : ld_model(rd, sz, sg, a[1:0]);
    e.at    = cyc + (to ? LIMIT : nst + 1);
    q.push_back(e);
    for (int k = 0; k <= LIMIT; k++) begin
      @(negedge clk);
      chk("mem_c_en", {31'b0, bus.mem_c_en}, 32'd1);
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_b_en", {28'b0, bus.mem_b_en}, {28'b0, eb});
      chk("mem_wdata", bus.mem_wdata, ew);
      bus.mem_stall = k < nst;
      bus.mem_rdata = k < nst ? $urandom : rd;
      bus.mem_error = k < nst ? 1'($urandom) : er;
      @(posedge clk);
      if (k >= nst || k + 1 == LIMIT) break;
    end
    @(negedge clk);
    chk("mem_c_en_drop", {31'b0, bus.mem_c_en}, 32'd0);
    bus.mem_stall = 1'b0;
    bus.mem_error = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_error = 1'b0;
    bus.mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_c_en", {31'b0, bus.mem_c_en}, 32'd0);
    chk("rst_mem_b_en", {28'b0, bus.mem_b_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b0);
    access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 10, 32'h12345678, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 0, 32'hCAFEF00D, 1'b1);
    access(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, LIMIT - 1, 32'h8001_7FFF, 1'b0);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'd2;
    bus.req_addr = 32'h300;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_stall = 1'b0;
    chk("rst_mid_mem_c_en", {31'b0, bus.mem_c_en}, 32'd0);
    chk("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 0, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 150; i++) begin
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access(1'($urandom), sz, 1'($urandom), a, $urandom,
             $urandom_range(0, 2) == 0 ? $urandom_range(0, 6) : 0, $urandom, $urandom_range(0, 7) == 0);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
